// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  // Arbiter sequencing states: a data access always goes before the fetch.
  typedef enum logic [1:0] {
    Idle,
    Data,
    Fetch,
    Done
  } arbiter_state_t;

  // addi x0, x0, 0: what the pipeline sees before any fetch has completed.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // The request latch is sized for the widest supported bus; narrower
  // instances zero-extend into it and use only the low bits.
  localparam int MAX_DATA_SIZE = 64;
  localparam int MAX_SEL_SIZE  = MAX_DATA_SIZE / 8;

  typedef struct packed {
    logic [MAX_DATA_SIZE-1:0] addr;
    logic [MAX_SEL_SIZE-1:0]  sel;
    logic                     we;
    logic [MAX_DATA_SIZE-1:0] wr_data;
  } bus_req_t;

endpackage

// File: rtl/arbiter_watchdog.sv
// Bus watchdog: counts strobe cycles without acknowledge and flags expiry
// in the cycle where the strobe would otherwise exceed TIMEOUT_CYCLES.
module arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            ENABLE = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST   = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the last allowed strobe cycle; an ack there wins.
  always_comb begin
    expire_o = ENABLE && active_i && !ack_i && (cnt_q == LAST);
  end

  // Count waiting strobe cycles; any completion or idle bus clears the count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!ENABLE || !active_i || ack_i || expire_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-ported memory bus between the fetch and load/store ports.
// Handshake: the bus master holds bus_stb with stable addr/sel/we/wr_data
// until a cycle where bus_stb && bus_ack (or the watchdog expires); ack is
// ignored whenever bus_stb is low and may arrive in the first strobe cycle.
module mem_access_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inst_req,
  input  logic [DATA_SIZE-1:0]   inst_addr,
  output logic [31:0]            inst,
  input  logic                   data_rd_en,
  input  logic                   data_wr_en,
  input  logic [DATA_SIZE/8-1:0] data_byte_en,
  input  logic [DATA_SIZE-1:0]   data_addr,
  input  logic [DATA_SIZE-1:0]   data_wr_data,
  output logic [DATA_SIZE-1:0]   data_rd_data,
  output logic                   mem_busy,
  output logic                   bus_cyc,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [DATA_SIZE/8-1:0] bus_sel,
  output logic [DATA_SIZE-1:0]   bus_addr,
  output logic [DATA_SIZE-1:0]   bus_wr_data,
  input  logic [DATA_SIZE-1:0]   bus_rd_data,
  input  logic                   bus_ack,
  output logic                   bus_error
);

  localparam int SEL_W = DATA_SIZE / 8;

  arbiter_state_t         state_q, state_d;
  bus_req_t               req_q, req_d;
  logic                   pend_fetch_q, pend_fetch_d;
  logic [DATA_SIZE-1:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]            inst_q, inst_d;
  logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   bus_error_q;

  logic                   xfer_active;
  logic                   expire;
  logic                   xfer_done;
  logic [DATA_SIZE-1:0]   xfer_data;
  logic [31:0]            fetch_word;
  logic                   unused_req;

  // A transfer is on the bus exactly in the Data and Fetch states.
  assign xfer_active = (state_q == Data) || (state_q == Fetch);

  arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clock),
    .rst_ni  (reset),
    .active_i(xfer_active),
    .ack_i   (bus_ack),
    .expire_o(expire)
  );

  // A watchdog abort completes the transfer with all-zero read data.
  assign xfer_done = bus_ack || expire;
  assign xfer_data = bus_ack ? bus_rd_data : '0;

  // On a 64-bit bus the instruction word is picked by address bit 2.
  if (DATA_SIZE == 64) begin : g_word_sel
    assign fetch_word = fetch_addr_q[2] ? xfer_data[63:32] : xfer_data[31:0];
  end else begin : g_word_direct
    assign fetch_word = xfer_data[31:0];
  end

  // Upper latch bits are unused on narrow buses.
  assign unused_req = ^req_q;

  // Next-state, latch updates and combinational bus/freeze outputs.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    pend_fetch_d = pend_fetch_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    rd_data_d    = rd_data_q;
    mem_busy     = 1'b0;
    bus_cyc      = 1'b0;
    bus_stb      = 1'b0;
    bus_we       = 1'b0;
    bus_sel      = '0;
    bus_addr     = '0;
    bus_wr_data  = '0;
    case (state_q)
      Idle: begin
        mem_busy = inst_req | data_rd_en | data_wr_en;
        if (data_rd_en || data_wr_en) begin
          req_d.addr    = MAX_DATA_SIZE'(data_addr);
          req_d.sel     = MAX_SEL_SIZE'(data_byte_en);
          req_d.we      = data_wr_en;
          req_d.wr_data = MAX_DATA_SIZE'(data_wr_data);
          pend_fetch_d  = inst_req;
          state_d       = Data;
        end else if (inst_req) begin
          fetch_addr_d = inst_addr;
          state_d      = Fetch;
        end
      end
      Data: begin
        mem_busy    = 1'b1;
        bus_cyc     = 1'b1;
        bus_stb     = 1'b1;
        bus_we      = req_q.we;
        bus_sel     = req_q.sel[SEL_W-1:0];
        bus_addr    = req_q.addr[DATA_SIZE-1:0];
        bus_wr_data = req_q.wr_data[DATA_SIZE-1:0];
        if (xfer_done) begin
          if (!req_q.we) begin
            rd_data_d = xfer_data;
          end
          if (pend_fetch_q) begin
            fetch_addr_d = inst_addr;
            state_d      = Fetch;
          end else begin
            state_d = Done;
          end
        end
      end
      Fetch: begin
        mem_busy = 1'b1;
        bus_cyc  = 1'b1;
        bus_stb  = 1'b1;
        bus_sel  = '1;
        bus_addr = fetch_addr_q;
        if (xfer_done) begin
          inst_d  = fetch_word;
          state_d = Done;
        end
      end
      Done: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  // State, request latches and holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= Idle;
      req_q        <= '0;
      pend_fetch_q <= 1'b0;
      fetch_addr_q <= '0;
      inst_q       <= NOP;
      rd_data_q    <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pend_fetch_q <= pend_fetch_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
      rd_data_q    <= rd_data_d;
      bus_error_q  <= expire;
    end
  end

  assign inst         = inst_q;
  assign data_rd_data = rd_data_q;
  assign bus_error    = bus_error_q;

  // A simultaneous load and store request is a requester bug; the store wins.
  assert property (@(posedge clock) disable iff (!reset)
    (state_q == Idle) |-> !(data_rd_en && data_wr_en));

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter (32-bit bus, 4-cycle watchdog).
module tb_mem_access_arbiter;

  localparam int          TMO     = 4;
  localparam logic [31:0] NOP_VAL = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        data_rd_en;
  logic        data_wr_en;
  logic [3:0]  data_byte_en;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [31:0] data_rd_data;
  logic        mem_busy;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_ack;
  logic        bus_error;

  int chk = 0;
  int err = 0;

  // Reference holding-register contents.
  logic [31:0] m_inst;
  logic [31:0] m_rd;

  mem_access_arbiter #(
    .DATA_SIZE     (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst        (inst),
    .data_rd_en  (data_rd_en),
    .data_wr_en  (data_wr_en),
    .data_byte_en(data_byte_en),
    .data_addr   (data_addr),
    .data_wr_data(data_wr_data),
    .data_rd_data(data_rd_data),
    .mem_busy    (mem_busy),
    .bus_cyc     (bus_cyc),
    .bus_stb     (bus_stb),
    .bus_we      (bus_we),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_ack     (bus_ack),
    .bus_error   (bus_error)
  );

  // Clock generation.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    inst_req     = 1'b0;
    data_rd_en   = 1'b0;
    data_wr_en   = 1'b0;
  endtask

  // Cycles with no request: the arbiter must sit idle whatever the bus does.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clear_reqs();
      bus_ack     = 1'($urandom_range(0, 1));
      bus_rd_data = $urandom;
      @(negedge clock);
      check("idle_busy", mem_busy, 1'b0);
      check("idle_stb", bus_stb, 1'b0);
      check("idle_cyc", bus_cyc, 1'b0);
      check("idle_err", bus_error, 1'b0);
      check("idle_inst", inst, m_inst);
      check("idle_rd", data_rd_data, m_rd);
      step_cycle();
    end
  endtask

  // One pipeline access: request cycle, optional data access, optional fetch,
  // then the single unfrozen cycle. A wait of w acks in strobe cycle w+1;
  // if that lies beyond TMO the access is aborted after TMO strobe cycles.
  task automatic run_txn(input bit rd, input bit wr, input bit fe,
                         input logic [31:0] daddr, input logic [3:0] be,
                         input logic [31:0] wdat, input logic [31:0] iaddr,
                         input int dwait, input int fwait,
                         input logic [31:0] dval, input logic [31:0] fval);
    bit has_d;
    bit d_to;
    bit f_to;
    int nd;
    int nf;
    has_d = rd | wr;
    d_to  = has_d && (dwait + 1 > TMO);
    f_to  = fe && (fwait + 1 > TMO);
    nd    = !has_d ? 0 : (d_to ? TMO : dwait + 1);
    nf    = !fe ? 0 : (f_to ? TMO : fwait + 1);

    inst_req     = fe;
    inst_addr    = iaddr;
    data_rd_en   = rd;
    data_wr_en   = wr;
    data_addr    = daddr;
    data_byte_en = be;
    data_wr_data = wdat;
    bus_ack      = 1'($urandom_range(0, 1));
    bus_rd_data  = $urandom;
    @(negedge clock);
    check("req_busy", mem_busy, 1'b1);
    check("req_stb", bus_stb, 1'b0);
    check("req_err", bus_error, 1'b0);
    check("req_inst", inst, m_inst);
    check("req_rd", data_rd_data, m_rd);
    step_cycle();

    for (int j = 1; j <= nd; j++) begin
      bus_ack     = (j == dwait + 1);
      bus_rd_data = bus_ack ? dval : $urandom;
      @(negedge clock);
      check("data_stb", bus_stb, 1'b1);
      check("data_cyc", bus_cyc, 1'b1);
      check("data_we", bus_we, wr);
      check("data_sel", bus_sel, be);
      check("data_addr", bus_addr, daddr);
      check("data_wdat", bus_wr_data, wdat);
      check("data_busy", mem_busy, 1'b1);
      check("data_err", bus_error, 1'b0);
      check("data_rd_hold", data_rd_data, m_rd);
      step_cycle();
    end
    if (has_d && !wr) m_rd = d_to ? 32'h0 : dval;

    for (int j = 1; j <= nf; j++) begin
      bus_ack     = (j == fwait + 1);
      bus_rd_data = bus_ack ? fval : $urandom;
      @(negedge clock);
      check("fetch_stb", bus_stb, 1'b1);
      check("fetch_cyc", bus_cyc, 1'b1);
      check("fetch_we", bus_we, 1'b0);
      check("fetch_sel", bus_sel, 4'hF);
      check("fetch_addr", bus_addr, iaddr);
      check("fetch_busy", mem_busy, 1'b1);
      check("fetch_err", bus_error, (j == 1) ? d_to : 1'b0);
      check("fetch_rd", data_rd_data, m_rd);
      check("fetch_inst_hold", inst, m_inst);
      step_cycle();
    end
    if (fe) m_inst = f_to ? 32'h0 : fval;

    clear_reqs();
    bus_ack     = 1'($urandom_range(0, 1));
    bus_rd_data = $urandom;
    @(negedge clock);
    check("done_busy", mem_busy, 1'b0);
    check("done_stb", bus_stb, 1'b0);
    check("done_cyc", bus_cyc, 1'b0);
    check("done_err", bus_error, fe ? f_to : d_to);
    check("done_inst", inst, m_inst);
    check("done_rd", data_rd_data, m_rd);
    step_cycle();
  endtask

  initial begin
    reset        = 1'b0;
    clear_reqs();
    inst_addr    = '0;
    data_addr    = '0;
    data_byte_en = '0;
    data_wr_data = '0;
    bus_rd_data  = '0;
    bus_ack      = 1'b0;
    m_inst       = NOP_VAL;
    m_rd         = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_inst", inst, NOP_VAL);
    check("rst_rd", data_rd_data, 32'h0);
    check("rst_stb", bus_stb, 1'b0);
    check("rst_cyc", bus_cyc, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_sel", bus_sel, 4'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdat", bus_wr_data, 32'h0);
    check("rst_err", bus_error, 1'b0);
    check("rst_busy", mem_busy, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_cycles(2);

    // Fetch only, zero wait.
    run_txn(0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h100, 0, 0, 32'h0, 32'h00A0_0093);
    // Load then fetch back-to-back.
    run_txn(1, 0, 1, 32'h2000, 4'hF, 32'h0, 32'h104, 0, 0, 32'hDEAD_BEEF, 32'h0010_0113);
    // Store with two wait-states.
    run_txn(0, 1, 0, 32'h3000, 4'b0011, 32'h1234, 32'h0, 2, 0, 32'h0, 32'h0);
    // Fetch never acknowledged: watchdog abort.
    run_txn(0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h200, 0, 9, 32'h0, 32'h0);
    // Load acknowledged in the timeout cycle: data kept, no error.
    run_txn(1, 0, 0, 32'h2400, 4'hF, 32'h0, 32'h0, TMO - 1, 0, 32'hCAFE_F00D, 32'h0);
    // Load timed out followed by a normal fetch.
    run_txn(1, 0, 1, 32'h2800, 4'hF, 32'h0, 32'h300, 7, 1, 32'h1111_2222, 32'h0030_0093);

    // Reset during a data wait-state.
    clear_reqs();
    data_rd_en   = 1'b1;
    data_addr    = 32'h4000;
    data_byte_en = 4'hF;
    bus_ack      = 1'b0;
    @(negedge clock);
    check("mid_req_busy", mem_busy, 1'b1);
    step_cycle();
    @(negedge clock);
    check("mid_stb_before", bus_stb, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    m_inst = NOP_VAL;
    m_rd   = '0;
    check("mid_rst_stb", bus_stb, 1'b0);
    check("mid_rst_cyc", bus_cyc, 1'b0);
    check("mid_rst_inst", inst, m_inst);
    check("mid_rst_rd", data_rd_data, m_rd);
    check("mid_rst_err", bus_error, 1'b0);
    clear_reqs();
    #1;
    check("mid_rst_busy", mem_busy, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_cycles(3);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int  kind;
      bit  rd;
      bit  wr;
      bit  fe;
      kind = $urandom_range(0, 5);
      if (kind == 5) begin
        idle_cycles($urandom_range(1, 3));
      end else begin
        rd = (kind == 1) || (kind == 3);
        wr = (kind == 2) || (kind == 4);
        fe = (kind == 0) || (kind == 3) || (kind == 4);
        run_txn(rd, wr, fe, $urandom, 4'($urandom_range(1, 15)), $urandom,
                $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
